// File: rtl/line_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with 4-word lines.
// Misses fill a whole line from a multi-cycle memory. Writes go straight
// through to memory and update the cached word only when the line is present.
module line_cache #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_LINES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [WORD_SIZE-1:0]   cpu_addr,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic [WORD_SIZE-1:0]   cpu_rdata,
  output logic                   cpu_ready,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic [WORD_SIZE-1:0]   num_hit,
  output logic [WORD_SIZE-1:0]   num_access
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - 2 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t               state, state_next;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  logic [WORD_SIZE-1:0] words [NUM_LINES][4];
  logic                 fill_pending;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;

  logic [1:0]           cpu_off, req_off;
  logic [IDX_W-1:0]     cpu_idx, req_idx;
  logic [TAG_W-1:0]     cpu_tag, req_tag;
  logic                 cpu_hit, req_hit, accept;

  // The outstanding request is decoded from the latched address so the
  // fill / write-through target cannot drift while the CPU stalls.
  assign cpu_off = cpu_addr[1:0];
  assign cpu_idx = cpu_addr[2 +: IDX_W];
  assign cpu_tag = cpu_addr[WORD_SIZE-1 -: TAG_W];
  assign req_off = addr_q[1:0];
  assign req_idx = addr_q[2 +: IDX_W];
  assign req_tag = addr_q[WORD_SIZE-1 -: TAG_W];
  assign cpu_hit = valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);
  assign req_hit = valid[req_idx] && (tags[req_idx] == req_tag);
  assign accept  = cpu_ready && (cpu_read || cpu_write);

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a write wins over a simultaneous read
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_write)                state_next = WRITE;
        else if (cpu_read && !cpu_hit) state_next = FILL;
      end
      FILL:    if (mem_ack) state_next = IDLE;
      WRITE:   if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: read hits and write acks complete combinationally
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && cpu_read && !cpu_write && cpu_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = words[cpu_idx][cpu_off];
        end
      end
      FILL:  mem_read = 1'b1;
      WRITE: begin
        mem_write = 1'b1;
        if (!reset && mem_ack) cpu_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latch, valid bits, fill-pending flag and statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      valid        <= '0;
      fill_pending <= 1'b0;
      num_hit      <= '0;
      num_access   <= '0;
    end else begin
      if (state == IDLE) begin
        if (cpu_write) begin
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
        end else if (cpu_read && !cpu_hit) begin
          addr_q <= {cpu_addr[WORD_SIZE-1:2], 2'b00};
        end
      end
      if (state == FILL && mem_ack) begin
        valid[req_idx] <= 1'b1;
        fill_pending   <= 1'b1;
      end
      if (accept) begin
        num_access   <= num_access + 1'b1;
        fill_pending <= 1'b0;
        if ((state == IDLE && !fill_pending) || (state == WRITE && req_hit))
          num_hit <= num_hit + 1'b1;
      end
    end
  end

  // Tag and data arrays: line fill on read ack, word update on write-hit ack
  always_ff @(posedge clk) begin
    if (state == FILL && mem_ack) begin
      tags[req_idx] <= req_tag;
      for (int unsigned k = 0; k < 4; k++)
        words[req_idx][k] <= mem_rdata[k*WORD_SIZE +: WORD_SIZE];
    end else if (state == WRITE && mem_ack && req_hit) begin
      words[req_idx][req_off] <= wdata_q;
    end
  end

endmodule

// File: doc/line_cache.md
Name: line_cache

Overview:
- Direct-mapped, write-through, no-write-allocate cache that sits directly downstream of the pipelined CPU's memory ports.
- One instance serves the instruction port and one serves the data port.
- It decouples the CPU from a multi-cycle, line-wide memory and stalls the CPU with cpu_ready=0 on misses and writes.
- It keeps hit and access counters so the team can measure hit ratio.

Parameters:
- WORD_SIZE, 16, width of address and data words.
- NUM_LINES, 8, number of lines; must be a power of two, minimum 2.
- Line size is fixed at 4 words, so offset = addr[1:0], index = addr[2+log2(NUM_LINES)-1:2], tag = remaining upper bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_read  in  1  CPU read request; held until accepted.
- cpu_write  in  1  CPU write request; held until accepted.
- cpu_addr  in  WORD_SIZE  word address.
- cpu_wdata  in  WORD_SIZE  write data.
- cpu_rdata  out  WORD_SIZE  read data; valid when cpu_ready=1 and cpu_read=1.
- cpu_ready  out  1  request accepted this cycle; the CPU stalls while 0.
- mem_read  out  1  line fill request.
- mem_write  out  1  single-word write-through request.
- mem_addr  out  WORD_SIZE  line base (addr with [1:0]=0) for fills; word address for writes.
- mem_wdata  out  WORD_SIZE  write-through data.
- mem_rdata  in  4*WORD_SIZE  fill line; word k is at bits [16k+15:16k].
- mem_ack  in  1  one-cycle completion pulse from memory, arriving at least 1 cycle after the request.
- num_hit  out  WORD_SIZE  hit counter.
- num_access  out  WORD_SIZE  accepted-request counter.

Behaviour:
- Interface clocking and reset: one clock; reset is synchronous and active-high.
- Reset action: while reset=1 at a posedge:
  - all valid bits clear and state goes to IDLE;
  - num_hit=0 and num_access=0;
  - the fill-pending flag clears.
- Outputs after reset: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, cpu_ready=0.
- Tag and data arrays need no reset.
- Reset mid-FILL or mid-WRITE: the transaction is abandoned and the request lines drop the next cycle. A stale mem_ack arriving later in IDLE is ignored.
- States: IDLE, FILL, WRITE.
- IDLE, read hit (valid and tag match):
  - cpu_ready=1 and cpu_rdata=line[index][offset], both combinational in the same cycle (0-cycle stall).
  - Stay in IDLE.
- IDLE, read miss: cpu_ready=0. Next state is FILL with mem_read=1 and mem_addr = {cpu_addr[15:2],2'b00}.
- FILL:
  - Hold mem_read and mem_addr stable until mem_ack.
  - On mem_ack: write the 4 words, the tag and valid=1 to the indexed line, set fill_pending, deassert mem_read and return to IDLE.
  - cpu_ready stays 0 during the ack cycle.
  - The held request hits in the following cycle. Miss penalty = memory latency + 1 cycle.
- IDLE, write (cpu_write=1): cpu_ready=0. Next state is WRITE with mem_write=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
- WRITE:
  - Hold outputs until mem_ack.
  - In the ack cycle: cpu_ready=1 combinationally; if the line is valid with a matching tag, update that word; return to IDLE.
  - On a write miss the line is untouched (no allocate).
- Simultaneous cpu_read=1 and cpu_write=1: treated as a write.
- mem_ack while in IDLE: ignored.
- Only one memory transaction is outstanding at a time. mem_read and mem_write are never both 1.
- Counters wrap modulo 2^WORD_SIZE.
- num_access increments by 1 at every posedge where cpu_ready=1 and (cpu_read or cpu_write).
- num_hit increments at an accepted read when fill_pending=0, or at an accepted write whose line matched at acceptance.
- fill_pending clears on every accepted request.
- cpu_rdata is 0 whenever cpu_ready=0.
- cpu_addr and cpu_wdata changing before acceptance is a protocol violation; behaviour is unspecified.

Test Plan:
1. Reset, then read 0x0012 with memory latency 3 returning line {0xD3,0xC2,0xB1,0xA0}:
   - mem_read=1 with mem_addr=0x0010 for 3 cycles;
   - cpu_ready=1 and cpu_rdata=0x00C2 on the cycle after the ack;
   - num_access=1, num_hit=0.
2. Read 0x0010, 0x0011, 0x0013 back-to-back after test 1:
   - cpu_ready=1 each cycle with 0x00A0, 0x00B1, 0x00D3;
   - no mem_read;
   - num_hit=3.
3. Write 0x1234 to 0x0011 (a hit):
   - mem_write=1 with mem_addr=0x0011 and mem_wdata=0x1234 until the ack;
   - cpu_ready is asserted in the ack cycle;
   - a subsequent read of 0x0011 returns 0x1234 with no fill.
4. Write 0x5555 to 0x0090 (a miss), then read 0x0090:
   - the write is not allocated;
   - the read issues a fill at mem_addr=0x0090;
   - num_hit is unchanged by the write.
5. Conflict: read 0x0010 then 0x0050 (same index 4, different tag):
   - both miss, and the second evicts the first;
   - re-reading 0x0010 misses again.
6. Assert reset in cycle 2 of a FILL:
   - mem_read=0 the next cycle and the counters are 0;
   - a late mem_ack is ignored;
   - re-reading 0x0012 misses.
